// File: rtl/watchdog_kicker_pkg.sv
`default_nettype none
// watchdog_kicker_pkg -- watchdog slave register map, bit positions and kicker FSM encoding.
// Revision 1.0
package watchdog_kicker_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam int STATUS_TO  = 0;
    localparam int STATUS_RUN = 1;
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_START = 2;

    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_KICK    = 3'd3,
        ST_STARVE  = 3'd4,
        ST_POLL    = 3'd5,
        ST_CAPTURE = 3'd6,
        ST_CLEAR   = 3'd7
    } state_e;

    function automatic logic [15:0] control_start_word(input logic irq_en);
        logic [15:0] w;
        w             = 16'h0000;
        w[CTRL_START] = 1'b1;
        w[CTRL_ITO]   = irq_en;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wdk_interval_counter.sv
`default_nettype none
// wdk_interval_counter -- loadable down-counter that parks at zero and flags it.
// Revision 1.0
module wdk_interval_counter
    import watchdog_kicker_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/watchdog_kicker.sv
`default_nettype none
// watchdog_kicker -- Avalon-MM master that starts a watchdog slave and kicks it while heartbeats arrive.
// Revision 1.0
module watchdog_kicker
    import watchdog_kicker_pkg::*;
#(
    parameter int KICK_INTERVAL = 500000,
    parameter int USE_IRQ       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        heartbeat,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic        m_read_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        wd_running,
    output logic        timeout_seen,
    output logic        starved,
    output logic [15:0] kick_count,
    output logic        busy
);

    localparam logic [CNT_W-1:0] C_RELOAD     = CNT_W'(KICK_INTERVAL - 1);
    localparam logic [15:0]      C_START_WORD = control_start_word(USE_IRQ != 0);

    state_e      state_q, state_d;
    logic        hb_seen_q, hb_seen_d;
    logic        wd_running_q, wd_running_d;
    logic        timeout_seen_q, timeout_seen_d;
    logic        starved_q, starved_d;
    logic [15:0] kick_count_q, kick_count_d;

    logic w_accept;
    logic w_zero;
    logic w_decide;
    logic w_load;
    logic w_unused_readdata;

    assign w_accept = m_chipselect && !m_waitrequest;
    assign w_decide = (state_q == ST_WAIT) && enable && w_zero;
    assign w_load   = (w_accept && ((state_q == ST_START) || (state_q == ST_CLEAR)))
                    || ((state_q == ST_CAPTURE) && !m_readdata[STATUS_TO]);
    assign w_unused_readdata = ^m_readdata[15:2];

    wdk_interval_counter u_interval (
        .clk          (clk),
        .reset        (reset),
        .load_i       (w_load),
        .load_value_i (C_RELOAD),
        .dec_i        (state_q == ST_WAIT),
        .zero_o       (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable) state_d = ST_START;
            ST_START:   if (!m_waitrequest) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (w_zero) begin
                    state_d = (hb_seen_q || heartbeat) ? ST_KICK : ST_STARVE;
                end
            end
            ST_KICK:    if (!m_waitrequest) state_d = ST_POLL;
            ST_STARVE:  state_d = ST_POLL;
            ST_POLL:    if (!m_waitrequest) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = m_readdata[STATUS_TO] ? ST_CLEAR : ST_WAIT;
            ST_CLEAR:   if (!m_waitrequest) state_d = ST_WAIT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus signals decode from state alone, so they hold while waitrequest stalls and drop on reset.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_read_n     = 1'b1;
        m_address    = ADDR_STATUS;
        m_writedata  = 16'h0000;
        busy         = 1'b1;
        case (state_q)
            ST_IDLE, ST_WAIT: busy = 1'b0;
            ST_START: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_CONTROL;
                m_writedata  = C_START_WORD;
            end
            ST_KICK: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_PERIODL;
            end
            ST_POLL: begin
                m_chipselect = 1'b1;
                m_read_n     = 1'b0;
            end
            ST_CLEAR: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        hb_seen_d      = hb_seen_q;
        wd_running_d   = wd_running_q;
        timeout_seen_d = timeout_seen_q;
        starved_d      = starved_q;
        kick_count_d   = kick_count_q;
        // A heartbeat landing in the decision cycle is consumed by that decision only.
        if (w_decide) begin
            hb_seen_d = 1'b0;
        end else if (heartbeat) begin
            hb_seen_d = 1'b1;
        end
        if ((state_q == ST_KICK) && w_accept) begin
            kick_count_d = kick_count_q + 16'd1;
            starved_d    = 1'b0;
        end
        if (state_q == ST_STARVE) begin
            starved_d = 1'b1;
        end
        if (state_q == ST_CAPTURE) begin
            wd_running_d = m_readdata[STATUS_RUN];
            if (m_readdata[STATUS_TO]) begin
                timeout_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_seen_q      <= 1'b0;
            wd_running_q   <= 1'b0;
            timeout_seen_q <= 1'b0;
            starved_q      <= 1'b0;
            kick_count_q   <= 16'h0000;
        end else begin
            hb_seen_q      <= hb_seen_d;
            wd_running_q   <= wd_running_d;
            timeout_seen_q <= timeout_seen_d;
            starved_q      <= starved_d;
            kick_count_q   <= kick_count_d;
        end
    end

    assign wd_running   = wd_running_q;
    assign timeout_seen = timeout_seen_q;
    assign starved      = starved_q;
    assign kick_count   = kick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_watchdog_kicker.sv
`timescale 1ns/1ps
`default_nettype none
// tb_watchdog_kicker -- directed vector table plus hand sequences against a small watchdog slave model.
// Revision 1.0
module tb_watchdog_kicker;

    localparam int K          = 8;
    localparam int SLV_PERIOD = 20;

    localparam logic [2:0] B_IDLE  = 3'd0;
    localparam logic [2:0] B_START = 3'd1;
    localparam logic [2:0] B_KICK  = 3'd2;
    localparam logic [2:0] B_POLL  = 3'd3;
    localparam logic [2:0] B_CLEAR = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        heartbeat = 1'b0;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic        m_read_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata = 16'hFFFF;
    logic        m_waitrequest = 1'b0;
    logic        wd_running;
    logic        timeout_seen;
    logic        starved;
    logic [15:0] kick_count;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    watchdog_kicker #(
        .KICK_INTERVAL (K),
        .USE_IRQ       (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .heartbeat     (heartbeat),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_read_n      (m_read_n),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .wd_running    (wd_running),
        .timeout_seen  (timeout_seen),
        .starved       (starved),
        .kick_count    (kick_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Watchdog slave model: read data is only meaningful the cycle after an accepted read.
    logic slv_run = 1'b0;
    logic slv_to  = 1'b0;
    int   slv_cnt = 0;
    int   wr_cnt [8] = '{default: 0};

    always @(posedge clk) begin
        if (m_chipselect && !m_waitrequest && !m_read_n) begin
            m_readdata <= {14'd0, slv_run, slv_to};
        end else begin
            m_readdata <= 16'hFFFF;
        end
        if (m_chipselect && !m_waitrequest && !m_write_n) begin
            wr_cnt[m_address] <= wr_cnt[m_address] + 1;
            case (m_address)
                3'd0: slv_to <= 1'b0;
                3'd1: if (m_writedata[2]) begin
                    slv_run <= 1'b1;
                    slv_cnt <= SLV_PERIOD;
                end
                3'd2: slv_cnt <= SLV_PERIOD;
                default: ;
            endcase
        end else if (slv_run && (slv_cnt != 0)) begin
            slv_cnt <= slv_cnt - 1;
            if (slv_cnt == 1) slv_to <= 1'b1;
        end
    end

    typedef struct {
        logic        en;
        logic        hb;
        logic [2:0]  bus;
        logic        busy;
        logic [15:0] kc;
        logic        st;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic en, input logic hb, input logic [2:0] bus,
                       input logic bsy, input logic [15:0] kc, input logic st);
        vec_t v;
        v.en = en; v.hb = hb; v.bus = bus; v.busy = bsy; v.kc = kc; v.st = st;
        tv.push_back(v);
    endtask

    // {chipselect, write_n, read_n, address, writedata}
    function automatic logic [21:0] bus_exp(input logic [2:0] b);
        case (b)
            B_START: return {1'b1, 1'b0, 1'b1, 3'd1, 16'h0005};
            B_KICK:  return {1'b1, 1'b0, 1'b1, 3'd2, 16'h0000};
            B_POLL:  return {1'b1, 1'b1, 1'b0, 3'd0, 16'h0000};
            B_CLEAR: return {1'b1, 1'b0, 1'b1, 3'd0, 16'h0000};
            default: return {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000};
        endcase
    endfunction

    function automatic logic [21:0] bus_act();
        return {m_chipselect, m_write_n, m_read_n, m_address, m_writedata};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_bus(input logic [2:0] b, input int limit, output logic found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus_act() == bus_exp(b)) found = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic found;
        logic cs_seen;

        // c0..c36: START, kick with early heartbeat, kick with decision-cycle heartbeat, starve
        add(0, 0, B_IDLE, 0, 16'd0, 0);
        add(1, 0, B_IDLE, 0, 16'd0, 0);
        add(1, 0, B_START, 1, 16'd0, 0);
        for (int i = 3; i <= 10; i++) add(1, (i == 5), B_IDLE, 0, 16'd0, 0);
        add(1, 0, B_KICK, 1, 16'd0, 0);
        add(1, 0, B_POLL, 1, 16'd1, 0);
        add(1, 0, B_IDLE, 1, 16'd1, 0);
        for (int i = 14; i <= 21; i++) add(1, (i == 21), B_IDLE, 0, 16'd1, 0);
        add(1, 0, B_KICK, 1, 16'd1, 0);
        add(1, 0, B_POLL, 1, 16'd2, 0);
        add(1, 0, B_IDLE, 1, 16'd2, 0);
        for (int i = 25; i <= 32; i++) add(1, 0, B_IDLE, 0, 16'd2, 0);
        add(1, 0, B_IDLE, 1, 16'd2, 0);
        add(1, 0, B_POLL, 1, 16'd2, 1);
        add(1, 0, B_IDLE, 1, 16'd2, 1);
        add(1, 0, B_IDLE, 0, 16'd2, 1);

        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {bus_act(), wd_running, timeout_seen, starved, kick_count, busy},
              {bus_exp(B_IDLE), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            enable    = tv[i].en;
            heartbeat = tv[i].hb;
            #1;
            check($sformatf("vec%0d", i), {bus_act(), busy, kick_count, starved},
                  {bus_exp(tv[i].bus), tv[i].busy, tv[i].kc, tv[i].st});
        end

        check("running_after_kicks", {wd_running, timeout_seen}, {1'b1, 1'b0});

        // Heartbeats withheld: slave times out, status 0x0003 is captured and cleared
        heartbeat = 1'b0;
        wait_bus(B_CLEAR, 100, found);
        check("clear_write_seen", found, 1'b1);
        check("timeout_flags", {timeout_seen, starved, wd_running}, {1'b1, 1'b1, 1'b1});
        check("no_kick_while_starved", wr_cnt[2], 2);
        check("kick_count_starved", kick_count, 16'd2);

        // Waitrequest held high across a KICK
        @(negedge clk);
        heartbeat = 1'b1;
        @(negedge clk);
        heartbeat = 1'b0;
        wait_bus(B_KICK, 40, found);
        check("kick_seen", found, 1'b1);
        m_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("kick_hold%0d", i), {bus_act(), kick_count}, {bus_exp(B_KICK), 16'd2});
            @(negedge clk);
            #1;
        end
        m_waitrequest = 1'b0;
        @(negedge clk);
        #1;
        check("kick_after_stall", {bus_act(), kick_count}, {bus_exp(B_POLL), 16'd3});
        repeat (3) @(negedge clk);
        #1;
        check("kick_single_increment", kick_count, 16'd3);

        // Disable: return to idle, nothing issued, counters persist; re-enable re-runs START
        enable = 1'b0;
        repeat (5) @(negedge clk);
        cs_seen = 1'b0;
        for (int i = 0; i < 3 * K; i++) begin
            @(negedge clk);
            #1;
            if (m_chipselect || busy) cs_seen = 1'b1;
        end
        check("disabled_quiet", cs_seen, 1'b0);
        check("disabled_persist", {kick_count, timeout_seen}, {16'd3, 1'b1});
        enable = 1'b1;
        wait_bus(B_START, 2, found);
        check("restart_write", found, 1'b1);

        // Reset in the middle of a POLL read
        heartbeat = 1'b1;
        @(negedge clk);
        heartbeat = 1'b0;
        wait_bus(B_POLL, 40, found);
        check("poll_seen", found, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_in_poll", {bus_act(), wd_running, timeout_seen, starved, kick_count, busy},
              {bus_exp(B_IDLE), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        wait_bus(B_START, 3, found);
        check("start_after_reset", found, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/watchdog_kicker.md
WATCHDOG_KICKER -- requirements
Module: watchdog_kicker

Interface
REQ-001 SHALL have parameter KICK_INTERVAL, default 500000, meaning clock cycles between kick decisions (valid range 4..2^20-1).
REQ-002 SHALL have parameter USE_IRQ, default 1, meaning the value written to control bit 0 (interrupt enable) at start.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level; high = start the watchdog and service it.
REQ-006 SHALL have port heartbeat  input  1  single-cycle pulse from system software/logic proving liveness.
REQ-007 SHALL have ports m_address output 3, m_chipselect output 1, m_write_n output 1, m_read_n output 1, m_writedata output 16, forming an Avalon-MM master toward the watchdog slave.
REQ-008 SHALL have ports m_readdata input 16 (valid exactly 1 cycle after the read cycle) and m_waitrequest input 1 (tie 0 when the slave has none).
REQ-009 SHALL have outputs wd_running 1, timeout_seen 1, starved 1, kick_count 16, busy 1.

Function
REQ-010 SHALL implement FSM states IDLE, START, WAIT, KICK, STARVE, POLL, CAPTURE, CLEAR.
REQ-011 IDLE: bus idle; when enable=1 -> START.
REQ-012 START: write address 1, data 0x0004 | USE_IRQ (bit 2 = START); on accept -> WAIT, interval counter loaded with KICK_INTERVAL-1.
REQ-013 A bus cycle is accepted in the cycle where m_chipselect=1 and m_waitrequest=0; all master outputs SHALL be held stable while m_waitrequest=1.
REQ-014 Writes drive m_write_n=0, m_read_n=1; reads drive m_read_n=0, m_write_n=1; idle drives chipselect=0, write_n=1, read_n=1, address 0, writedata 0.
REQ-015 WAIT: interval counter decrements by 1 per cycle; at 0 is the decision cycle: heartbeat_seen or heartbeat this cycle -> KICK, else -> STARVE; heartbeat_seen cleared in the decision cycle.
REQ-016 heartbeat_seen SHALL set on any heartbeat outside the decision cycle; a heartbeat in the decision cycle counts toward that decision only.
REQ-017 KICK: write address 2, data 0x0000 (forces slave reload); on accept kick_count increments (wraps 0xFFFF->0), starved clears; -> POLL.
REQ-018 STARVE: no write issued; starved sets for one cycle transition; -> POLL.
REQ-019 POLL: read address 0; on accept -> CAPTURE.
REQ-020 CAPTURE: samples m_readdata; wd_running <= bit 1; if bit 0 = 1, timeout_seen sets (sticky) and -> CLEAR, else -> WAIT (counter reloaded).
REQ-021 CLEAR: write address 0, data 0x0000 (clears slave timeout); on accept -> WAIT (counter reloaded).
REQ-022 enable=0 SHALL be sampled only in WAIT (-> IDLE); an in-flight transaction always completes; no stop command is ever written (slave cannot stop).
REQ-023 Re-enable from IDLE SHALL re-run START; kick_count, timeout_seen persist.
REQ-024 busy SHALL be 1 in every state except IDLE and WAIT.
REQ-025 Kick-to-kick period with waitrequest=0 SHALL be exactly KICK_INTERVAL+3 cycles when no timeout is reported.

Reset
REQ-026 reset SHALL asynchronously force IDLE, interval counter 0, heartbeat_seen 0, and all outputs to: bus idle per REQ-014, wd_running 0, timeout_seen 0, starved 0, kick_count 0, busy 0.
REQ-027 reset mid-transaction SHALL drop chipselect immediately; no partial cycle resumes after release.

Structure
REQ-028 Shared package SHALL hold watchdog register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3), bit indices (TO=0, RUN=1, ITO=0, START=2) and the FSM state enum.
REQ-029 One sub-module, wdk_interval_counter (loadable 20-bit down-counter with zero flag), SHALL be instantiated; the rest is flat.

Verification
REQ-030 enable 0->1, waitrequest 0 -> write addr 1 data 0x0005 within 2 cycles, then first KICK write addr 2 at KICK_INTERVAL cycles later; kick_count=1.
REQ-031 KICK_INTERVAL=8, heartbeat pulsed every interval, model slave attached -> kicks every 11 cycles, slave never times out, timeout_seen stays 0, wd_running=1.
REQ-032 heartbeats withheld -> no addr-2 write, starved=1; slave model returns status 0x0003 -> timeout_seen=1 and write addr 0 data 0 follows.
REQ-033 m_waitrequest held high 5 cycles during KICK -> address/data/write_n stable all 5 cycles, single increment of kick_count.
REQ-034 heartbeat exactly in decision cycle -> KICK issued; heartbeat_seen 0 afterwards.
REQ-035 reset asserted during POLL read -> chipselect 0 same cycle, all outputs at reset values; after release with enable=1, START write reissued.
